// File: rtl/data_mem_unit.sv
// Byte-addressed little-endian data memory for the MEM stage.
// Byte/half/word access, sign/zero extension, configurable read latency.
module data_mem_unit #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk_in,
    input  logic        n_rst_in,
    input  logic        req_valid_in,
    input  logic        req_write_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        busy_out,
    output logic        rdata_valid_out,
    output logic [31:0] rdata_out,
    output logic        fault_out
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] CNT_INIT =
        (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

    logic [31:0] mem [DEPTH];

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [2:0]  cnt;
    logic [31:0] word_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        uns_q;

    logic                  accept;
    logic                  bad;
    logic                  do_store;
    logic                  do_load;
    logic [ADDR_WIDTH-3:0] idx;
    logic [3:0]            be;
    logic [31:0]           wrep;
    logic [31:0]           shifted;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;

    assign idx      = addr_in[ADDR_WIDTH-1:2];
    assign busy_out = (state == WAIT);
    assign accept   = req_valid_in && !busy_out;

    assign bad = (size_in == 2'b11)
              || (size_in == 2'b01 && addr_in[0])
              || (size_in == 2'b10 && addr_in[1:0] != 2'b00)
              || ((addr_in >> ADDR_WIDTH) != 32'd0);

    assign do_store = accept && !bad && req_write_in;
    assign do_load  = accept && !bad && !req_write_in;

    // Replicate store data across lanes so byte enables alone pick the target.
    always_comb begin
        be   = 4'b1111;
        wrep = wdata_in;
        case (size_in)
            2'b00: begin
                be   = 4'b0001 << addr_in[1:0];
                wrep = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                be   = addr_in[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata_in[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = wdata_in;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wrep[b*8 +: 8];
                end
            end
        end
        if (do_load) begin
            word_q <= mem[idx];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, RESP: begin
                if (do_load) begin
                    state_nxt = (READ_LATENCY > 1) ? WAIT : RESP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            size_q    <= 2'b00;
            lane_q    <= 2'b00;
            uns_q     <= 1'b0;
            fault_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            fault_out <= accept && bad;
            if (do_load) begin
                cnt    <= CNT_INIT;
                size_q <= size_in;
                lane_q <= addr_in[1:0];
                uns_q  <= unsigned_in;
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    assign shifted = word_q >> {lane_q, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = lane_q[1] ? word_q[31:16] : word_q[15:0];

    assign rdata_valid_out = (state == RESP);

    always_comb begin
        rdata_out = 32'd0;
        if (state == RESP) begin
            case (size_q)
                2'b00:   rdata_out = {{24{~uns_q & byte_v[7]}}, byte_v};
                2'b01:   rdata_out = {{16{~uns_q & half_v[15]}}, half_v};
                default: rdata_out = word_q;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit at read latencies 1, 3 and 4.
// Expected values are hand-computed constants.
module tb_data_mem_unit;

    logic        clk;
    logic        n_rst;
    logic        req_write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        valid1, valid3, valid4;
    logic        busy1, busy3, busy4;
    logic        rv1, rv3, rv4;
    logic [31:0] rd1, rd3, rd4;
    logic        ft1, ft3, ft4;

    int nchk = 0;
    int nerr = 0;
    logic busy1_seen = 1'b0;
    logic rv4_seen;

    data_mem_unit #(.ADDR_WIDTH(10), .READ_LATENCY(1)) u1 (
        .clk_in(clk), .n_rst_in(n_rst), .req_valid_in(valid1),
        .req_write_in(req_write), .size_in(size), .unsigned_in(uns),
        .addr_in(addr), .wdata_in(wdata), .busy_out(busy1),
        .rdata_valid_out(rv1), .rdata_out(rd1), .fault_out(ft1)
    );

    data_mem_unit #(.ADDR_WIDTH(10), .READ_LATENCY(3)) u3 (
        .clk_in(clk), .n_rst_in(n_rst), .req_valid_in(valid3),
        .req_write_in(req_write), .size_in(size), .unsigned_in(uns),
        .addr_in(addr), .wdata_in(wdata), .busy_out(busy3),
        .rdata_valid_out(rv3), .rdata_out(rd3), .fault_out(ft3)
    );

    data_mem_unit #(.ADDR_WIDTH(10), .READ_LATENCY(4)) u4 (
        .clk_in(clk), .n_rst_in(n_rst), .req_valid_in(valid4),
        .req_write_in(req_write), .size_in(size), .unsigned_in(uns),
        .addr_in(addr), .wdata_in(wdata), .busy_out(busy4),
        .rdata_valid_out(rv4), .rdata_out(rd4), .fault_out(ft4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy1) busy1_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic get_rv(input int s);
        case (s)
            1:       return rv1;
            3:       return rv3;
            default: return rv4;
        endcase
    endfunction

    function automatic logic [31:0] get_rd(input int s);
        case (s)
            1:       return rd1;
            3:       return rd3;
            default: return rd4;
        endcase
    endfunction

    task automatic set_valid(input int s, input logic v);
        case (s)
            1:       valid1 = v;
            3:       valid3 = v;
            default: valid4 = v;
        endcase
    endtask

    task automatic req(input int s, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] d);
        req_write = w;
        size      = sz;
        uns       = u;
        addr      = a;
        wdata     = d;
        set_valid(s, 1'b1);
        @(posedge clk);
        #1;
        set_valid(s, 1'b0);
    endtask

    task automatic load_wait(input int s, input logic [1:0] sz,
                             input logic u, input logic [31:0] a,
                             input logic [31:0] exp, input int lat,
                             input string tag);
        int n = 0;
        req(s, 1'b0, sz, u, a, 32'd0);
        while (!get_rv(s) && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_data"}, get_rd(s), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic fault_req(input logic w, input logic [1:0] sz,
                             input logic [31:0] a, input string tag);
        req(1, w, sz, 1'b0, a, 32'd0);
        check({tag, "_fault"}, {31'd0, ft1}, 32'd1);
        check({tag, "_norv"}, {31'd0, rv1}, 32'd0);
        check({tag, "_nobusy"}, {31'd0, busy1}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_fault_end"}, {31'd0, ft1}, 32'd0);
    endtask

    initial begin
        n_rst = 1'b0;
        valid1 = 1'b0;
        valid3 = 1'b0;
        valid4 = 1'b0;
        req_write = 1'b0;
        size = 2'b00;
        uns = 1'b0;
        addr = 32'd0;
        wdata = 32'd0;

        #12;
        check("rst_busy", {31'd0, busy4}, 32'd0);
        check("rst_rv", {31'd0, rv1}, 32'd0);
        check("rst_rd", rd1, 32'd0);
        check("rst_fault", {31'd0, ft1}, 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        req(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw_nofault", {31'd0, ft1}, 32'd0);
        check("sw_norv", {31'd0, rv1}, 32'd0);
        load_wait(1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, "lw1");
        check("lw1_rv_drop", {31'd0, rv1}, 32'd0);
        check("lw1_rd_zero", rd1, 32'd0);

        req(1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680);
        load_wait(1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF80, 0, "lb_s");
        load_wait(1, 2'b00, 1'b1, 32'h13, 32'h00000080, 0, "lb_u");
        load_wait(1, 2'b10, 1'b0, 32'h10, 32'h80ADBEEF, 0, "lw2");
        load_wait(1, 2'b00, 1'b1, 32'h10, 32'h000000EF, 0, "lb0_u");
        load_wait(1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFBE, 0, "lb1_s");
        load_wait(1, 2'b01, 1'b0, 32'h12, 32'hFFFF80AD, 0, "lh_s");
        load_wait(1, 2'b01, 1'b1, 32'h10, 32'h0000BEEF, 0, "lh_u");
        req(1, 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234);
        load_wait(1, 2'b10, 1'b0, 32'h10, 32'h1234BEEF, 0, "lw3");

        fault_req(1'b0, 2'b01, 32'h11, "f_half");
        fault_req(1'b1, 2'b10, 32'h12, "f_word");
        fault_req(1'b0, 2'b11, 32'h10, "f_size");
        fault_req(1'b1, 2'b10, 32'h410, "f_range");
        load_wait(1, 2'b10, 1'b0, 32'h10, 32'h1234BEEF, 0, "lw_after_f");

        // Two loads back to back on the latency-3 instance.
        req(3, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111);
        req(3, 1'b1, 2'b10, 1'b0, 32'h24, 32'h22222222);
        req_write = 1'b0;
        size = 2'b10;
        uns = 1'b0;
        addr = 32'h20;
        valid3 = 1'b1;
        @(posedge clk);
        #1;
        addr = 32'h24;
        check("l3a_busy0", {31'd0, busy3}, 32'd1);
        check("l3a_norv0", {31'd0, rv3}, 32'd0);
        @(posedge clk);
        #1;
        check("l3a_busy1", {31'd0, busy3}, 32'd1);
        @(posedge clk);
        #1;
        check("l3a_busy2", {31'd0, busy3}, 32'd0);
        check("l3a_rv", {31'd0, rv3}, 32'd1);
        check("l3a_data", rd3, 32'h11111111);
        @(posedge clk);
        #1;
        valid3 = 1'b0;
        check("l3b_busy0", {31'd0, busy3}, 32'd1);
        check("l3b_norv0", {31'd0, rv3}, 32'd0);
        @(posedge clk);
        #1;
        check("l3b_busy1", {31'd0, busy3}, 32'd1);
        @(posedge clk);
        #1;
        check("l3b_busy2", {31'd0, busy3}, 32'd0);
        check("l3b_rv", {31'd0, rv3}, 32'd1);
        check("l3b_data", rd3, 32'h22222222);
        @(posedge clk);
        #1;
        check("l3b_rv_drop", {31'd0, rv3}, 32'd0);

        // Reset in the middle of a latency-4 load.
        req(4, 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D);
        req(4, 1'b0, 2'b10, 1'b0, 32'h30, 32'd0);
        check("l4_busy0", {31'd0, busy4}, 32'd1);
        @(posedge clk);
        #1;
        check("l4_busy1", {31'd0, busy4}, 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check("l4_rst_busy", {31'd0, busy4}, 32'd0);
        check("l4_rst_rv", {31'd0, rv4}, 32'd0);
        check("l4_rst_rd", rd4, 32'd0);
        check("l4_rst_fault", {31'd0, ft4}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        n_rst = 1'b1;
        rv4_seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rv4) rv4_seen = 1'b1;
        end
        check("l4_no_resp", {31'd0, rv4_seen}, 32'd0);
        load_wait(4, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 3, "l4_again");

        check("l1_never_busy", {31'd0, busy1_seen}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised data-memory unit for the MEM stage: a byte-addressed, little-endian RAM with byte/halfword/word loads and stores, signed or unsigned load extension, configurable read latency with a stall output, and alignment/range fault detection. It replaces the fixed 256-word, word-indexed, zero-latency data memory. The EX/MEM register drives requests; load responses feed the MEM/WB register.

## Interface
- ADDR_WIDTH, 10: byte-address bits decoded; capacity 2^(ADDR_WIDTH-2) 32-bit words; legal range 4..16.
- READ_LATENCY, 1: cycles from read acceptance to response; legal range 1..4.

- clk_in  input  1  single clock, all state on rising edge.
- n_rst_in  input  1  asynchronous, active-low reset.
- req_valid_in  input  1  request present.
- req_write_in  input  1  1 = store, 0 = load.
- size_in  input  2  2'b00 byte, 2'b01 halfword, 2'b10 word, 2'b11 reserved.
- unsigned_in  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- addr_in  input  32  byte address.
- wdata_in  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- busy_out  output  1  1 = request not accepted this cycle.
- rdata_valid_out  output  1  one-cycle load-response strobe.
- rdata_out  output  32  extended load data; 0 when rdata_valid_out = 0.
- fault_out  output  1  one-cycle strobe: previous accepted request faulted.

## Operation
- Acceptance: req_valid_in && !busy_out sampled at a rising edge.
- Fault check at acceptance: size_in = 2'b11; halfword with addr_in[0] = 1; word with addr_in[1:0] != 0; or addr_in[31:ADDR_WIDTH] != 0. A faulted request performs no write and produces no response; it sets fault_out for the following cycle and leaves busy_out at 0.
- Store (no fault): completes at the accepting edge. Word index is addr_in[ADDR_WIDTH-1:2]. Byte writes lane addr_in[1:0] with wdata_in[7:0]. Halfword writes lanes {addr_in[1],0} and {addr_in[1],1} with wdata_in[15:0]. Word writes all lanes. Unwritten lanes are preserved. No response and no busy.
- Load (no fault): the addressed word is captured at the accepting edge, then extracted and extended.
  - Byte: lane addr_in[1:0].
  - Halfword: lanes selected by addr_in[1].
  - Extension uses the top bit of the extracted field, unless unsigned_in = 1.
- FSM states:
  - IDLE: -> WAIT on accepting a load when READ_LATENCY > 1; -> RESP when READ_LATENCY = 1.
  - WAIT: a down-counter (3 bits) is loaded with READ_LATENCY-2 and decremented each cycle; -> RESP when it reaches 0.
  - RESP: rdata_valid_out = 1; -> IDLE, or straight back to WAIT/RESP if a new load is accepted in this cycle.
- busy_out = 1 only in WAIT. It is 0 in RESP, so back-to-back loads are accepted.
- Memory array is not reset; contents persist across n_rst_in.

## Timing
- Reset (asynchronous, n_rst_in low):
  - FSM goes to IDLE; counter cleared.
  - busy_out = 0, rdata_valid_out = 0, rdata_out = 0, fault_out = 0.
  - An in-flight load is dropped with no response.
- Load accepted at edge E0 with latency L: response appears in the cycle after edge E0+L-1.
  - busy_out is high in the L-1 cycles after E0 (never high when L = 1).
- Store accepted at E0: new data is visible to a load accepted at E0+1.
- A store and a load can never overlap: requests are blocked while busy_out is high, so captured data cannot change mid-flight.
- fault_out is high exactly in the cycle after the faulting acceptance edge.
- Inputs are ignored while busy_out = 1; the requester holds its request until accepted.

## Test plan
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10, L=1: rdata_valid_out high one cycle after acceptance with rdata_out = 0xDEADBEEF; busy_out never 1.
- Byte store 0x80 to addr 0x13, then loads from 0x13 -> signed 0xFFFFFF80, unsigned 0x00000080; word load from 0x10 -> 0x80ADBEEF.
- Halfword load from addr 0x12 with word 0x80ADBEEF -> signed 0xFFFF80AD; halfword store 0x1234 to 0x12 -> word reads 0x1234BEEF.
- L=3: two consecutive loads requested back to back -> busy_out high 2 cycles after each acceptance; the second load is accepted in the first response cycle; responses arrive 3 cycles apart, correct data.
- Faults: halfword at 0x11, word at 0x12, size 2'b11, address 1<<ADDR_WIDTH -> fault_out pulses one cycle each; memory unchanged; no rdata_valid_out.
- L=4 load accepted, then n_rst_in asserted 2 cycles later -> all outputs 0 immediately; no response after release; a subsequent load returns previously stored data.
